// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer
//
// Commit-trace capture for the multicycle CPU. Retired instructions are
// written as records into an on-chip ring buffer. After capture ends, the
// records drain oldest-first as a stream of 32-bit words over a
// valid/ready handshake.
//
// Optional feature macro: TRACE_REGWRITE_EN
//   defined     : 4-word records {pc, inst, {rf_we,26'b0,rf_waddr}, rf_wdata}
//   not defined : 2-word records {pc, inst}; the rf_* inputs are ignored
//
// Ports
//   clk_in        clock, all logic on the rising edge
//   reset         synchronous active-high reset
//   arm           start a new capture (IDLE/DONE only)
//   stop          end the capture (CAPTURE only)
//   commit_*      retiring instruction tap (valid, pc, inst)
//   rf_*          register-file write that accompanies the commit
//   rd_ready      consumer accepts rd_data
//   rd_valid      rd_data holds a valid word
//   rd_data       drained word
//   rd_last       final word of the final record
//   state         0 IDLE, 1 CAPTURE, 2 DRAIN, 3 DONE
//   count         records currently stored
//   overflow      at least one commit was dropped or overwritten
//   commits       accepted commits since arm, saturating
module cpu_trace_buffer #(
    parameter int DEPTH       = 64,
    parameter int ADDR_W      = 6,
    parameter int MAX_COMMITS = 1000,
    parameter int WRAP        = 0
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              arm,
    input  logic              stop,
    input  logic              commit_valid,
    input  logic [31:0]       commit_pc,
    input  logic [31:0]       commit_inst,
    input  logic              rf_we,
    input  logic [4:0]        rf_waddr,
    input  logic [31:0]       rf_wdata,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [31:0]       rd_data,
    output logic              rd_last,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [31:0]       commits
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

`ifdef TRACE_REGWRITE_EN
    localparam int WPR   = 4;
    localparam int REC_W = 102;
`else
    localparam int WPR   = 2;
    localparam int REC_W = 64;
`endif

    localparam logic [1:0]        LAST_WORD = 2'(WPR - 1);
    localparam logic [ADDR_W:0]   CNT_ZERO  = '0;
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    // Record layout: pc [31:0], inst [63:32], waddr [68:64], we [69],
    // wdata [101:70] (the last three only with register-write capture).
    logic [REC_W-1:0] mem [DEPTH];
    logic [REC_W-1:0] ram_q;
    logic [REC_W-1:0] wr_rec;
    logic             wr_en;
    logic [ADDR_W-1:0] rd_addr;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       commits_q, commits_d;
    logic              overflow_q, overflow_d;
    logic [1:0]        word_idx_q, word_idx_d;
    logic              rd_valid_q, rd_valid_d;

    logic        fire;
    logic        rec_done;
    logic        full;
    logic [31:0] commits_inc;

`ifdef TRACE_REGWRITE_EN
    always_comb begin
        wr_rec = {rf_wdata, rf_we, rf_waddr, commit_inst, commit_pc};
    end
`else
    logic unused_rf;
    assign unused_rf = ^{rf_we, rf_waddr, rf_wdata};

    always_comb begin
        wr_rec = {commit_inst, commit_pc};
    end
`endif

    // Buffer: one write port in CAPTURE, registered read for DRAIN.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_rec;
        end
        ram_q <= mem[rd_addr];
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            commits_q  <= '0;
            overflow_q <= 1'b0;
            word_idx_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            commits_q  <= commits_d;
            overflow_q <= overflow_d;
            word_idx_q <= word_idx_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        commits_d   = commits_q;
        overflow_d  = overflow_q;
        word_idx_d  = word_idx_q;
        rd_valid_d  = rd_valid_q;
        wr_en       = 1'b0;

        fire        = rd_valid_q && rd_ready;
        rec_done    = fire && (word_idx_q == LAST_WORD);
        full        = count_q[ADDR_W];
        commits_inc = (commits_q == 32'hFFFF_FFFF) ? commits_q : commits_q + 32'd1;

        // Prefetch: as the last word of a record leaves, the RAM is already
        // addressed at the next record so its data lands with no bubble.
        rd_addr     = rec_done ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_d    = ST_CAPTURE;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    count_d    = '0;
                    commits_d  = '0;
                    overflow_d = 1'b0;
                    word_idx_d = '0;
                    rd_valid_d = 1'b0;
                end
            end

            ST_CAPTURE: begin
                word_idx_d = '0;
                if (commit_valid) begin
                    if (!full) begin
                        wr_en     = 1'b1;
                        wr_ptr_d  = wr_ptr_q + PTR_ONE;
                        count_d   = count_q + CNT_ONE;
                        commits_d = commits_inc;
                    end else if (WRAP != 0) begin
                        // Oldest record is overwritten, so the read side moves too.
                        wr_en      = 1'b1;
                        wr_ptr_d   = wr_ptr_q + PTR_ONE;
                        rd_ptr_d   = rd_ptr_q + PTR_ONE;
                        overflow_d = 1'b1;
                        commits_d  = commits_inc;
                    end else begin
                        overflow_d = 1'b1;
                        state_d    = ST_DRAIN;
                    end
                end
                if (stop || ((MAX_COMMITS != 0) && (commits_d >= 32'(MAX_COMMITS)))) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (count_q == CNT_ZERO) begin
                    state_d = ST_DONE;
                end else begin
                    // First DRAIN cycle only primes the RAM read.
                    rd_valid_d = 1'b1;
                    if (fire) begin
                        if (rec_done) begin
                            word_idx_d = '0;
                            rd_ptr_d   = rd_ptr_q + PTR_ONE;
                            count_d    = count_q - CNT_ONE;
                            if (count_q == CNT_ONE) begin
                                state_d    = ST_DONE;
                                rd_valid_d = 1'b0;
                            end
                        end else begin
                            word_idx_d = word_idx_q + 2'd1;
                        end
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_data = 32'd0;
        case (word_idx_q)
            2'd0: rd_data = ram_q[31:0];
            2'd1: rd_data = ram_q[63:32];
`ifdef TRACE_REGWRITE_EN
            2'd2: rd_data = {ram_q[69], 26'd0, ram_q[68:64]};
            2'd3: rd_data = ram_q[101:70];
`endif
            default: rd_data = 32'd0;
        endcase
    end

    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_valid_q && (word_idx_q == LAST_WORD) && (count_q == CNT_ONE);
    assign state    = state_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign commits  = commits_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed testbench for cpu_trace_buffer. Four instances cover the
// different parameter sets: A (64 deep, stop-when-full), B (4 deep,
// stop-when-full), C (4 deep, wrap, unlimited), D (64 deep, 5-commit limit).
// Only one instance is armed at a time; the others sit idle.
module tb_cpu_trace_buffer;

`ifdef TRACE_REGWRITE_EN
    localparam int WPR = 4;
`else
    localparam int WPR = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  arm_v = 4'd0;
    logic        stop = 1'b0;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_pc = 32'd0;
    logic [31:0] commit_inst = 32'd0;
    logic        rf_we = 1'b0;
    logic [4:0]  rf_waddr = 5'd0;
    logic [31:0] rf_wdata = 32'd0;
    logic        rd_ready = 1'b0;

    logic        rv_a, rv_b, rv_c, rv_d;
    logic        rl_a, rl_b, rl_c, rl_d;
    logic [31:0] rd_a, rd_b, rd_c, rd_d;
    logic [1:0]  st_a, st_b, st_c, st_d;
    logic [6:0]  cnt_a, cnt_d;
    logic [2:0]  cnt_b, cnt_c;
    logic        ov_a, ov_b, ov_c, ov_d;
    logic [31:0] cm_a, cm_b, cm_c, cm_d;

    always #5 clk = ~clk;

    cpu_trace_buffer #(.DEPTH(64), .ADDR_W(6), .MAX_COMMITS(1000), .WRAP(0)) dut_a (
        .clk_in(clk), .reset(reset), .arm(arm_v[0]), .stop(stop),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rd_ready(rd_ready),
        .rd_valid(rv_a), .rd_data(rd_a), .rd_last(rl_a), .state(st_a),
        .count(cnt_a), .overflow(ov_a), .commits(cm_a));

    cpu_trace_buffer #(.DEPTH(4), .ADDR_W(2), .MAX_COMMITS(1000), .WRAP(0)) dut_b (
        .clk_in(clk), .reset(reset), .arm(arm_v[1]), .stop(stop),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rd_ready(rd_ready),
        .rd_valid(rv_b), .rd_data(rd_b), .rd_last(rl_b), .state(st_b),
        .count(cnt_b), .overflow(ov_b), .commits(cm_b));

    cpu_trace_buffer #(.DEPTH(4), .ADDR_W(2), .MAX_COMMITS(0), .WRAP(1)) dut_c (
        .clk_in(clk), .reset(reset), .arm(arm_v[2]), .stop(stop),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rd_ready(rd_ready),
        .rd_valid(rv_c), .rd_data(rd_c), .rd_last(rl_c), .state(st_c),
        .count(cnt_c), .overflow(ov_c), .commits(cm_c));

    cpu_trace_buffer #(.DEPTH(64), .ADDR_W(6), .MAX_COMMITS(5), .WRAP(0)) dut_d (
        .clk_in(clk), .reset(reset), .arm(arm_v[3]), .stop(stop),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rd_ready(rd_ready),
        .rd_valid(rv_d), .rd_data(rd_d), .rd_last(rl_d), .state(st_d),
        .count(cnt_d), .overflow(ov_d), .commits(cm_d));

    // Selected-instance view used by the shared tasks.
    int          sel = 0;
    logic        rv, rl, ov;
    logic [31:0] rd, cnt, cm;
    logic [1:0]  st;

    always_comb begin
        rv = rv_a; rl = rl_a; rd = rd_a; st = st_a; cnt = 32'(cnt_a); ov = ov_a; cm = cm_a;
        case (sel)
            1: begin rv = rv_b; rl = rl_b; rd = rd_b; st = st_b; cnt = 32'(cnt_b); ov = ov_b; cm = cm_b; end
            2: begin rv = rv_c; rl = rl_c; rd = rd_c; st = st_c; cnt = 32'(cnt_c); ov = ov_c; cm = cm_c; end
            3: begin rv = rv_d; rl = rl_d; rd = rd_d; st = st_d; cnt = 32'(cnt_d); ov = ov_d; cm = cm_d; end
            default: ;
        endcase
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Commit history of the current test (the reference model).
    logic [31:0] h_pc   [16];
    logic [31:0] h_inst [16];
    logic        h_we   [16];
    logic [4:0]  h_wa   [16];
    logic [31:0] h_wd   [16];
    int          nh = 0;

    logic [31:0] words [64];
    logic        lasts [64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int r, input int w);
        case (w)
            0: return h_pc[r];
            1: return h_inst[r];
            2: return {h_we[r], 26'd0, h_wa[r]};
            default: return h_wd[r];
        endcase
    endfunction

    task automatic commit(input logic [31:0] pc, input logic [31:0] inst,
                          input logic we, input logic [4:0] wa, input logic [31:0] wd);
        commit_valid = 1'b1;
        commit_pc = pc; commit_inst = inst;
        rf_we = we; rf_waddr = wa; rf_wdata = wd;
        h_pc[nh] = pc; h_inst[nh] = inst; h_we[nh] = we; h_wa[nh] = wa; h_wd[nh] = wd;
        nh++;
        @(negedge clk);
        commit_valid = 1'b0;
    endtask

    task automatic pulse_arm(input int idx);
        arm_v[idx] = 1'b1;
        @(negedge clk);
        arm_v = 4'd0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    // Collects drained words; bp applies the 1,0,0,1 rd_ready pattern and
    // checks that rd_data holds through every stall.
    task automatic drain(input bit bp, output int n, output bit saw_v);
        logic [31:0] held;
        bit          holding;
        n = 0; saw_v = 1'b0; holding = 1'b0; held = 32'd0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (st == 2'd3 && !rv) break;
            rd_ready = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            if (rv) saw_v = 1'b1;
            if (holding && rv) chk("stall_stable", rd, held);
            if (rv && rd_ready) begin
                if (n < 64) begin
                    words[n] = rd;
                    lasts[n] = rl;
                end
                n++;
                holding = 1'b0;
            end else if (rv) begin
                held = rd;
                holding = 1'b1;
            end
            @(negedge clk);
        end
        rd_ready = 1'b0;
        chk("drain_end_state", 32'(st), 32'd3);
        chk("drain_end_valid", 32'(rv), 32'd0);
        chk("drain_end_count", cnt, 32'd0);
    endtask

    task automatic check_records(input int base, input int nrec, input int n);
        int tot;
        tot = nrec * WPR;
        chk("word_count", n, tot);
        for (int i = 0; i < tot && i < n; i++) begin
            chk($sformatf("word%0d", i), words[i], exp_word(base + i / WPR, i % WPR));
            chk($sformatf("last%0d", i), 32'(lasts[i]), 32'(i == tot - 1));
        end
    endtask

    initial begin
        int  n;
        bit  sv;
        int  got;

        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sel = 0;
        chk("rst_state", 32'(st), 32'd0);
        chk("rst_valid", 32'(rv), 32'd0);
        chk("rst_last", 32'(rl), 32'd0);
        chk("rst_count", cnt, 32'd0);
        chk("rst_overflow", 32'(ov), 32'd0);
        chk("rst_commits", cm, 32'd0);

        // Basic capture
        nh = 0;
        pulse_arm(0);
        chk("basic_capture", 32'(st), 32'd1);
        commit(32'h0040_0000, 32'h3c01_0000, 1'b0, 5'd0, 32'd0);
        commit(32'h0040_0004, 32'h3c01_0000, 1'b1, 5'd1, 32'h1001_0000);
        commit(32'h0040_0008, 32'h3c01_0000, 1'b0, 5'd0, 32'd0);
        pulse_stop();
        chk("basic_drain_state", 32'(st), 32'd2);
        chk("basic_valid_lag", 32'(rv), 32'd0);
        chk("basic_count", cnt, 32'd3);
        chk("basic_commits", cm, 32'd3);
        chk("basic_overflow", 32'(ov), 32'd0);
        drain(1'b0, n, sv);
        check_records(0, 3, n);

        // Backpressure
        nh = 0;
        pulse_arm(0);
        commit(32'h0000_1000, 32'h1111_1111, 1'b1, 5'd7, 32'hDEAD_BEEF);
        commit(32'h0000_1004, 32'h2222_2222, 1'b0, 5'd3, 32'h0000_0000);
        pulse_stop();
        drain(1'b1, n, sv);
        check_records(0, 2, n);

        // Reset mid-drain after 2 words
        nh = 0;
        pulse_arm(0);
        commit(32'h0000_2000, 32'h3333_3333, 1'b0, 5'd0, 32'd0);
        commit(32'h0000_2004, 32'h4444_4444, 1'b0, 5'd0, 32'd0);
        pulse_stop();
        rd_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            if (rv) got++;
            @(negedge clk);
        end
        chk("pre_reset_words", got, 32'd2);
        rd_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_state", 32'(st), 32'd0);
        chk("midrst_valid", 32'(rv), 32'd0);
        chk("midrst_count", cnt, 32'd0);
        pulse_arm(0);
        pulse_stop();
        drain(1'b0, n, sv);
        chk("empty_words", n, 32'd0);
        chk("empty_never_valid", 32'(sv), 32'd0);

        // Stop-when-full, DEPTH=4
        sel = 1; nh = 0;
        pulse_arm(1);
        for (int i = 0; i < 6; i++)
            commit(32'h0000_0100 + 32'(4 * i), 32'h0000_2000 + 32'(i), 1'b0, 5'(i), 32'(i));
        chk("full_state", 32'(st), 32'd2);
        chk("full_count", cnt, 32'd4);
        chk("full_overflow", 32'(ov), 32'd1);
        chk("full_commits", cm, 32'd4);
        drain(1'b0, n, sv);
        check_records(0, 4, n);

        // Wrap, DEPTH=4
        sel = 2; nh = 0;
        pulse_arm(2);
        for (int i = 0; i < 10; i++)
            commit(32'(4 * i), 32'h0000_1000 + 32'(i), 1'(i & 1), 5'(i), 32'hA000_0000 + 32'(i));
        chk("wrap_still_capture", 32'(st), 32'd1);
        pulse_stop();
        chk("wrap_count", cnt, 32'd4);
        chk("wrap_overflow", 32'(ov), 32'd1);
        chk("wrap_commits", cm, 32'd10);
        drain(1'b0, n, sv);
        check_records(6, 4, n);

        // MAX_COMMITS=5
        sel = 3; nh = 0;
        pulse_arm(3);
        for (int i = 0; i < 7; i++) begin
            commit(32'h0000_3000 + 32'(4 * i), 32'h0000_5000 + 32'(i), 1'b1, 5'(i + 2), 32'(i * 3));
            if (i == 4) begin
                chk("max_drain_after_5th", 32'(st), 32'd2);
                chk("max_commits_at_5th", cm, 32'd5);
            end
        end
        chk("max_commits", cm, 32'd5);
        chk("max_count", cnt, 32'd5);
        chk("max_overflow", 32'(ov), 32'd0);
        drain(1'b0, n, sv);
        check_records(0, 5, n);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
